// File: rtl/stepper_move_segmenter.sv
// Splits one signed relative (dx, dy) move into per-axis chunks of at most +/-CHUNK_MAX steps
// and sequences them to the X/Y stepper controllers. Optional abort input: STEPPER_SEG_ABORT_EN.
module stepper_move_segmenter #(
    parameter int MOVE_BITS  = 16,
    parameter int COUNT_BITS = 8,
    parameter int WIDTH_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic                         start,
    input  logic signed [MOVE_BITS-1:0]  dx,
    input  logic signed [MOVE_BITS-1:0]  dy,
    input  logic        [WIDTH_BITS-1:0] pulse_width,
    input  logic                         x_done,
    input  logic                         y_done,
`ifdef STEPPER_SEG_ABORT_EN
    input  logic                         abort,
`endif
    output logic signed [COUNT_BITS-1:0] x_num_steps,
    output logic signed [COUNT_BITS-1:0] y_num_steps,
    output logic        [WIDTH_BITS-1:0] step_width,
    output logic                         trigger,
    output logic                         done
);

    localparam int CHUNK_MAX = 2**(COUNT_BITS-1) - 1;

    localparam logic signed [MOVE_BITS-1:0]  REM_HI = MOVE_BITS'(CHUNK_MAX);
    localparam logic signed [MOVE_BITS-1:0]  REM_LO = -REM_HI;
    localparam logic signed [COUNT_BITS-1:0] CNT_HI = COUNT_BITS'(CHUNK_MAX);
    localparam logic signed [COUNT_BITS-1:0] CNT_LO = -CNT_HI;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHUNK,
        S_ISSUE,
        S_SETTLE,
        S_WAIT
    } state_t;

    state_t                       state_q;
    logic signed [MOVE_BITS-1:0]  rem_x_q, rem_y_q;
    logic signed [MOVE_BITS-1:0]  rem_x_d, rem_y_d;
    logic signed [COUNT_BITS-1:0] x_num_q, y_num_q;
    logic signed [COUNT_BITS-1:0] chunk_x_d, chunk_y_d;
    logic        [WIDTH_BITS-1:0] step_width_q;
    logic                         trigger_q;
    logic                         done_q;
    logic                         abort_pend_q;
    logic                         abort_w;

`ifdef STEPPER_SEG_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Symmetric clamp: the most negative remainder maps to -CHUNK_MAX, never overflowing the count.
    function automatic logic signed [COUNT_BITS-1:0] clamp_chunk(
        input logic signed [MOVE_BITS-1:0] rem
    );
        if (rem > REM_HI)
            return CNT_HI;
        else if (rem < REM_LO)
            return CNT_LO;
        else
            return rem[COUNT_BITS-1:0];
    endfunction

    always_comb begin
        chunk_x_d = clamp_chunk(rem_x_q);
        chunk_y_d = clamp_chunk(rem_y_q);
        rem_x_d   = rem_x_q - MOVE_BITS'(x_num_q);
        rem_y_d   = rem_y_q - MOVE_BITS'(y_num_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rem_x_q      <= '0;
            rem_y_q      <= '0;
            x_num_q      <= '0;
            y_num_q      <= '0;
            step_width_q <= '0;
            trigger_q    <= 1'b0;
            done_q       <= 1'b1;
            abort_pend_q <= 1'b0;
        end else if (clk_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && (dx != '0 || dy != '0)) begin
                        rem_x_q      <= dx;
                        rem_y_q      <= dy;
                        step_width_q <= pulse_width;
                        abort_pend_q <= 1'b0;
                        done_q       <= 1'b0;
                        state_q      <= S_CHUNK;
                    end
                end
                S_CHUNK: begin
                    if (abort_w) begin
                        rem_x_q <= '0;
                        rem_y_q <= '0;
                        x_num_q <= '0;
                        y_num_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        x_num_q   <= chunk_x_d;
                        y_num_q   <= chunk_y_d;
                        trigger_q <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    trigger_q <= 1'b0;
                    state_q   <= S_SETTLE;
                    if (abort_w) begin
                        rem_x_q      <= '0;
                        rem_y_q      <= '0;
                        abort_pend_q <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    state_q <= S_WAIT;
                    if (abort_w) begin
                        rem_x_q      <= '0;
                        rem_y_q      <= '0;
                        abort_pend_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (x_done && y_done) begin
                        // An aborted move drops whatever remainder the subtraction would leave.
                        if (abort_w || abort_pend_q || (rem_x_d == '0 && rem_y_d == '0)) begin
                            rem_x_q      <= '0;
                            rem_y_q      <= '0;
                            x_num_q      <= '0;
                            y_num_q      <= '0;
                            abort_pend_q <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= S_IDLE;
                        end else begin
                            rem_x_q <= rem_x_d;
                            rem_y_q <= rem_y_d;
                            state_q <= S_CHUNK;
                        end
                    end else if (abort_w) begin
                        rem_x_q      <= '0;
                        rem_y_q      <= '0;
                        abort_pend_q <= 1'b1;
                    end
                end
                default: begin
                    trigger_q <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign x_num_steps = x_num_q;
    assign y_num_steps = y_num_q;
    assign step_width  = step_width_q;
    assign trigger     = trigger_q;
    assign done        = done_q;

endmodule

// File: tb/tb_stepper_move_segmenter.sv
// Bench for stepper_move_segmenter: a behavioural pair of axis controllers plus a chunk scoreboard.
// Define STEPPER_SEG_ABORT_EN for both files to exercise the abort input.
module tb_stepper_move_segmenter;

    localparam int CHUNK_MAX = 127;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_en;
    logic               start;
    logic signed [15:0] dx;
    logic signed [15:0] dy;
    logic        [7:0]  pw;
    logic               x_done = 1'b1;
    logic               y_done = 1'b1;
    logic signed [7:0]  x_num_steps;
    logic signed [7:0]  y_num_steps;
    logic        [7:0]  step_width;
    logic               trigger;
    logic               done;
`ifdef STEPPER_SEG_ABORT_EN
    logic               abort;
`endif

    stepper_move_segmenter #(
        .MOVE_BITS (16),
        .COUNT_BITS(8),
        .WIDTH_BITS(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .start      (start),
        .dx         (dx),
        .dy         (dy),
        .pulse_width(pw),
        .x_done     (x_done),
        .y_done     (y_done),
`ifdef STEPPER_SEG_ABORT_EN
        .abort      (abort),
`endif
        .x_num_steps(x_num_steps),
        .y_num_steps(y_num_steps),
        .step_width (step_width),
        .trigger    (trigger),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int w;
    } chunk_t;

    chunk_t sb[$];
    chunk_t mon_e;
    int     total = 0;
    int     bad   = 0;
    int     busy  = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Controllers drop done when triggered and finish 1+pulse_width clk_en's later.
    always @(negedge clk) begin
        if (reset) begin
            busy   = 0;
            x_done = 1'b1;
            y_done = 1'b1;
        end else if (clk_en) begin
            if (trigger === 1'b1) begin
                busy   = 1 + int'(step_width);
                x_done = 1'b0;
                y_done = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    x_done = 1'b1;
                    y_done = 1'b1;
                end
            end
        end
    end

    // Every trigger must match the next expected chunk.
    always @(negedge clk) begin
        if (!reset && clk_en && trigger === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_trigger", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("x_chunk", $signed(x_num_steps), mon_e.x);
                check("y_chunk", $signed(y_num_steps), mon_e.y);
                check("step_width", {24'd0, step_width}, mon_e.w);
            end
        end
    end

    function automatic int clamp(input int v);
        if (v > CHUNK_MAX) return CHUNK_MAX;
        if (v < -CHUNK_MAX) return -CHUNK_MAX;
        return v;
    endfunction

    task automatic push_move(input int mx, input int my, input int mw);
        int rx;
        int ry;
        int cx;
        int cy;
        rx = mx;
        ry = my;
        while (rx != 0 || ry != 0) begin
            cx = clamp(rx);
            cy = clamp(ry);
            sb.push_back('{cx, cy, mw});
            rx -= cx;
            ry -= cy;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic launch(input int mx, input int my, input int mw);
        dx    = 16'(mx);
        dy    = 16'(my);
        pw    = 8'(mw);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 6000) begin
            tick(1);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 6000), 1);
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    task automatic wait_trigger(input string tag);
        int n;
        n = 0;
        while (trigger !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_trig_timeout"}, 32'(n < 200), 1);
    endtask

    task automatic wait_ctrl_done(input string tag);
        int n;
        n = 0;
        while (x_done !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_ctrl_timeout"}, 32'(n < 200), 1);
    endtask

    initial begin
        int trig_seen;
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dx     = '0;
        dy     = '0;
        pw     = '0;
`ifdef STEPPER_SEG_ABORT_EN
        abort  = 1'b0;
`endif
        tick(3);
        reset = 1'b0;

        check("rst_done", 32'(done), 1);
        check("rst_trigger", 32'(trigger), 0);
        check("rst_x_num", $signed(x_num_steps), 0);
        check("rst_y_num", $signed(y_num_steps), 0);
        check("rst_width", {24'd0, step_width}, 0);

        // Mixed-sign move split into three chunks.
        push_move(300, -50, 4);
        launch(300, -50, 4);
        check("m300_busy", 32'(done), 0);
        wait_idle("m300");
        check("m300_x_zero", $signed(x_num_steps), 0);

        // Null move: never triggers, done stays high.
        trig_seen = 0;
        launch(0, 0, 3);
        repeat (10) begin
            if (trigger === 1'b1) trig_seen++;
            tick(1);
        end
        check("zero_trig", trig_seen, 0);
        check("zero_done", 32'(done), 1);

        // Most negative move with zero pulse width: 259 chunks.
        push_move(-32768, 5, 0);
        launch(-32768, 5, 0);
        wait_idle("mneg");

        // Start mid-move is ignored; a relatched width or remainder would show in the chunks.
        push_move(300, -50, 2);
        launch(300, -50, 2);
        wait_trigger("ign");
        dx    = 16'sd10;
        dy    = 16'sd0;
        pw    = 8'd7;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle("ign");

        // clk_en low for 20 cycles in WAIT with both controllers done.
        push_move(200, 0, 4);
        launch(200, 0, 4);
        wait_trigger("cen");
        wait_ctrl_done("cen");
        clk_en = 1'b0;
        repeat (20) begin
            tick(1);
            check("cen_hold_done", 32'(done), 0);
            check("cen_hold_trig", 32'(trigger), 0);
            check("cen_hold_x", $signed(x_num_steps), 127);
        end
        clk_en = 1'b1;
        wait_idle("cen");

        // Reset while waiting on the controllers abandons the move.
        push_move(300, 0, 4);
        launch(300, 0, 4);
        wait_trigger("rstw");
        wait_ctrl_done("rstw");
        reset = 1'b1;
        tick(1);
        check("rstw_done", 32'(done), 1);
        check("rstw_trig", 32'(trigger), 0);
        check("rstw_x_num", $signed(x_num_steps), 0);
        check("rstw_y_num", $signed(y_num_steps), 0);
        sb.delete();
        reset = 1'b0;
        tick(30);
        check("rstw_idle", 32'(done), 1);

`ifdef STEPPER_SEG_ABORT_EN
        // Abort during chunk 1: that chunk completes, no second trigger.
        sb.push_back('{127, -50, 4});
        launch(300, -50, 4);
        wait_trigger("abt");
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_idle("abt");
        tick(20);
        check("abt_idle", 32'(done), 1);
        check("abt_x_num", $signed(x_num_steps), 0);
`endif

        check("final_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
